// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default sizing for the store buffer
package mem_pkg;
    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;
    typedef enum logic [1:0] {PORT_IDLE, PORT_LOAD, PORT_DRAIN} sb_port_mode_t;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: pipeline-side and memory-side signals of the store buffer
interface store_buffer_if import mem_pkg::*; #(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
);
    logic                         st_valid;
    logic                         st_ready;
    logic [ADDR_W-1:0]            st_addr;
    logic [DATA_W-1:0]            st_data;
    logic                         ld_valid;
    logic                         ld_ready;
    logic [ADDR_W-1:0]            ld_addr;
    logic [DATA_W-1:0]            ld_data;
    logic                         ld_hit;
    logic                         mem_write_enable;
    logic [ADDR_W-1:0]            mem_address;
    logic [DATA_W-1:0]            mem_write_data;
    logic [DATA_W-1:0]            mem_read_data;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         empty;
    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
        input  st_ready, ld_ready, ld_data, ld_hit, mem_write_enable, mem_address,
               mem_write_data, count, empty
    );
    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
        output st_ready, ld_ready, ld_data, ld_hit, mem_write_enable, mem_address,
               mem_write_data, count, empty
    );
endinterface

// File: rtl/store_buffer_match.sv
// store_buffer_match: finds the youngest occupied entry whose address equals the load address
module store_buffer_match import mem_pkg::*; #(
    parameter int DEPTH = SB_DEPTH
) (
    input  sb_entry_t                    entries [DEPTH],
    input  logic [DEPTH-1:0]             valid,
    input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
    input  logic [SB_ADDR_W-1:0]         ld_addr,
    output logic                         hit,
    output logic [SB_DATA_W-1:0]         data
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] idx;
    // walk oldest to youngest so the last match seen is the youngest
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (valid[idx] && entries[idx].addr == ld_addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO in front of a single-port data memory with load forwarding
module store_buffer import mem_pkg::*; #(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input logic           clock,
    input logic           reset_n,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    sb_entry_t            entries [DEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr, off;
    logic [CW-1:0]        cnt;
    logic [DEPTH-1:0]     valid;
    logic                 st_rdy, ld_rdy, push, drain, hit;
    logic [SB_DATA_W-1:0] hit_data;
    sb_port_mode_t        mode;
    assign st_rdy = reset_n && cnt < FULL;
    assign ld_rdy = reset_n && cnt != FULL;
    assign push   = sb.st_valid && st_rdy;
    assign drain  = mode == PORT_DRAIN;
    // occupancy mask: entry j is live when its distance from the head is below count
    always_comb begin
        off   = '0;
        valid = '0;
        for (int j = 0; j < DEPTH; j++) begin
            off      = PW'(j) - rd_ptr;
            valid[j] = CW'(off) < cnt;
        end
    end
    store_buffer_match #(.DEPTH(DEPTH)) u_match (
        .entries (entries),
        .valid   (valid),
        .rd_ptr  (rd_ptr),
        .ld_addr (SB_ADDR_W'(sb.ld_addr)),
        .hit     (hit),
        .data    (hit_data)
    );
    // memory port owner: a served load wins, otherwise drain the head when anything is held
    always_comb begin
        mode = !reset_n ? PORT_IDLE :
               (sb.ld_valid && ld_rdy) ? PORT_LOAD :
               (cnt != '0) ? PORT_DRAIN : PORT_IDLE;
    end
    assign sb.st_ready        = st_rdy;
    assign sb.ld_ready        = ld_rdy;
    assign sb.mem_write_enable = drain;
    assign sb.mem_address     = mode == PORT_LOAD ? sb.ld_addr :
                                drain ? ADDR_W'(entries[rd_ptr].addr) : '0;
    assign sb.mem_write_data  = drain ? DATA_W'(entries[rd_ptr].data) : '0;
    assign sb.ld_hit          = mode == PORT_LOAD && hit;
    assign sb.ld_data         = mode != PORT_LOAD ? '0 : hit ? DATA_W'(hit_data) : sb.mem_read_data;
    assign sb.count           = cnt;
    assign sb.empty           = !reset_n || cnt == '0;
    // pointers and occupancy; reset discards every buffered store
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (drain) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(drain);
        end
    end
    // entry payload needs no reset since occupancy gates every use
    always_ff @(posedge clock) begin
        if (push) entries[wr_ptr] <= '{addr: SB_ADDR_W'(sb.st_addr), data: SB_DATA_W'(sb.st_data)};
    end
    a_no_overflow:  assert property (@(posedge clock) disable iff (!reset_n) !(push && cnt == FULL));
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n) !(drain && cnt == '0));
    a_count_range:  assert property (@(posedge clock) disable iff (!reset_n) cnt <= FULL);
endmodule
